// File: rtl/memory_port_arbiter.sv
// -----------------------------------------------------------------------------
// memory_port_arbiter
//
// Purpose:
//   Shares one single-port RAM between the LC-3 core memory sequencer
//   (requester 0, "core") and a program loader / debug port (requester 1,
//   "loader"). Each access runs IDLE -> ACCESS -> RESPOND. The winner's id,
//   write flag, address and data are captured at the grant. The RAM strobes
//   are driven for exactly one cycle (ACCESS). The winner is acknowledged
//   with a one-cycle pulse in RESPOND.
//
// Configuration macro:
//   ARBITER_ROUND_ROBIN_EN - when defined, simultaneous requests alternate
//                            using a one-bit last-grant pointer. When
//                            undefined, the loader always beats the core.
//
// Ports:
//   clock, reset              system clock, synchronous active-high reset
//   core_request/_write       core access request and direction
//   core_address/_write_data  core access address and write data
//   core_read_data            read data, valid while core_acknowledge = 1
//   core_acknowledge          one-cycle completion pulse to the core
//   core_stall                loader granted or pending; holds the core FSM
//   loader_*                  same set of signals for the loader
//   memory_read/_write        RAM strobes (never both high)
//   memory_address/_in_data   RAM address and write data
//   memory_out_data           RAM read data, valid the cycle after memory_read
// -----------------------------------------------------------------------------
module memory_port_arbiter #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  // requester 0: core
  input  logic                     core_request,
  input  logic                     core_write,
  input  logic [ADDRESS_WIDTH-1:0] core_address,
  input  logic [DATA_WIDTH-1:0]    core_write_data,
  output logic [DATA_WIDTH-1:0]    core_read_data,
  output logic                     core_acknowledge,
  output logic                     core_stall,
  // requester 1: loader
  input  logic                     loader_request,
  input  logic                     loader_write,
  input  logic [ADDRESS_WIDTH-1:0] loader_address,
  input  logic [DATA_WIDTH-1:0]    loader_write_data,
  output logic [DATA_WIDTH-1:0]    loader_read_data,
  output logic                     loader_acknowledge,
  // RAM side
  output logic                     memory_read,
  output logic                     memory_write,
  output logic [ADDRESS_WIDTH-1:0] memory_address,
  output logic [DATA_WIDTH-1:0]    memory_in_data,
  input  logic [DATA_WIDTH-1:0]    memory_out_data
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_RESPOND = 2'd2
  } state_t;

  localparam logic ID_CORE   = 1'b0;
  localparam logic ID_LOADER = 1'b1;

  state_t                   r_state;
  logic                     r_id;
  logic                     r_write;
  logic                     r_core_ack;
  logic                     r_loader_ack;
  logic                     r_memory_read;
  logic                     r_memory_write;
  logic [ADDRESS_WIDTH-1:0] r_memory_address;
  logic [DATA_WIDTH-1:0]    r_memory_in_data;
  logic [DATA_WIDTH-1:0]    r_core_read_data;
  logic [DATA_WIDTH-1:0]    r_loader_read_data;

  logic                     w_any_request;
  logic                     w_grant_loader;
  logic                     w_grant_write;
  logic [ADDRESS_WIDTH-1:0] w_grant_address;
  logic [DATA_WIDTH-1:0]    w_grant_data;
  logic                     w_read_returning;

  assign w_any_request = core_request | loader_request;

`ifdef ARBITER_ROUND_ROBIN_EN
  // Last granted requester; on a tie the other one wins.
  logic r_last_grant;

  always_comb begin
    w_grant_loader = loader_request;
    if (core_request && loader_request) begin
      w_grant_loader = (r_last_grant == ID_CORE);
    end
  end
`else
  // Fixed priority: any loader request beats the core.
  assign w_grant_loader = loader_request;
`endif

  assign w_grant_write   = w_grant_loader ? loader_write      : core_write;
  assign w_grant_address = w_grant_loader ? loader_address    : core_address;
  assign w_grant_data    = w_grant_loader ? loader_write_data : core_write_data;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state            <= ST_IDLE;
      r_id               <= ID_CORE;
      r_write            <= 1'b0;
      r_core_ack         <= 1'b0;
      r_loader_ack       <= 1'b0;
      r_memory_read      <= 1'b0;
      r_memory_write     <= 1'b0;
      r_memory_address   <= '0;
      r_memory_in_data   <= '0;
      r_core_read_data   <= '0;
      r_loader_read_data <= '0;
`ifdef ARBITER_ROUND_ROBIN_EN
      r_last_grant       <= ID_CORE;
`endif
    end else begin
      // Strobes and acknowledges are single-cycle pulses by default.
      r_core_ack     <= 1'b0;
      r_loader_ack   <= 1'b0;
      r_memory_read  <= 1'b0;
      r_memory_write <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_request) begin
            // The address/data registers double as the RAM-side outputs,
            // so later requester-side changes cannot disturb the access.
            r_id             <= w_grant_loader;
            r_write          <= w_grant_write;
            r_memory_address <= w_grant_address;
            r_memory_in_data <= w_grant_data;
            r_memory_write   <= w_grant_write;
            r_memory_read    <= ~w_grant_write;
`ifdef ARBITER_ROUND_ROBIN_EN
            r_last_grant     <= w_grant_loader;
`endif
            r_state          <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_core_ack   <= (r_id == ID_CORE);
          r_loader_ack <= (r_id == ID_LOADER);
          r_state      <= ST_RESPOND;
        end
        ST_RESPOND: begin
          if (!r_write) begin
            if (r_id == ID_LOADER) begin
              r_loader_read_data <= memory_out_data;
            end else begin
              r_core_read_data <= memory_out_data;
            end
          end
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // RAM read data only arrives during RESPOND, the same cycle as the
  // acknowledge, so it is forwarded straight through then and held in the
  // register afterwards. Reset masks both the acknowledge and the forward
  // so an access interrupted in RESPOND is never reported as complete.
  assign w_read_returning = (r_state == ST_RESPOND) && !r_write && !reset;

  assign core_read_data     = (w_read_returning && (r_id == ID_CORE))
                              ? memory_out_data : r_core_read_data;
  assign loader_read_data   = (w_read_returning && (r_id == ID_LOADER))
                              ? memory_out_data : r_loader_read_data;
  assign core_acknowledge   = r_core_ack & ~reset;
  assign loader_acknowledge = r_loader_ack & ~reset;

  assign core_stall = loader_request |
                      ((r_state != ST_IDLE) && (r_id == ID_LOADER));

  assign memory_read    = r_memory_read;
  assign memory_write   = r_memory_write;
  assign memory_address = r_memory_address;
  assign memory_in_data = r_memory_in_data;

endmodule

// File: doc/memory_port_arbiter.md
Name: memory_port_arbiter

Overview:
- Shares the single-port 16x16 RAM between two requesters: the LC-3 core memory sequencing (requester 0, "core") and a program loader/debug port (requester 1, "loader").
- Sits between both requesters and the RAM's read/write/address/in_data/out_data pins.
- Serialises accesses, drives the RAM strobes and returns read data with a one-cycle acknowledge.
- Also produces a stall indication the core controller uses to hold its FSM while the loader owns memory.

Parameters:
- ADDRESS_WIDTH, 16, RAM address width.
- DATA_WIDTH, 16, RAM data width.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- core_request  input  1  core access request; held high until core_acknowledge.
- core_write  input  1  1 = write, 0 = read; qualified by core_request.
- core_address  input  ADDRESS_WIDTH  core access address.
- core_write_data  input  DATA_WIDTH  core write data.
- core_read_data  output  DATA_WIDTH  read data; valid when core_acknowledge = 1.
- core_acknowledge  output  1  one-cycle completion pulse to the core.
- core_stall  output  1  high while the loader is granted or pending.
- loader_request  input  1  loader access request; held high until loader_acknowledge.
- loader_write  input  1  1 = write, 0 = read.
- loader_address  input  ADDRESS_WIDTH  loader access address.
- loader_write_data  input  DATA_WIDTH  loader write data.
- loader_read_data  output  DATA_WIDTH  read data; valid when loader_acknowledge = 1.
- loader_acknowledge  output  1  one-cycle completion pulse to the loader.
- memory_read  output  1  RAM read strobe.
- memory_write  output  1  RAM write strobe.
- memory_address  output  ADDRESS_WIDTH  RAM address.
- memory_in_data  output  DATA_WIDTH  RAM write data.
- memory_out_data  input  DATA_WIDTH  RAM read data; valid the cycle after memory_read.

Behaviour:
- Clocking and reset: single clock domain; reset is synchronous and active-high.
- Reset values: state IDLE; all acknowledges, strobes and core_stall = 0; read data outputs = 0; memory_address and memory_in_data = 0; grant pointer = core.
- IDLE:
  - No request: stay in IDLE, strobes 0.
  - Any request: arbitrate and capture the winner's id, write flag, address and data into registers. Go to ACCESS.
- ACCESS (1 cycle):
  - memory_address and memory_in_data come from the captured registers.
  - memory_write = captured write; memory_read = not captured write.
  - Go to RESPOND.
- RESPOND (1 cycle):
  - Pulse the winner's acknowledge.
  - For a read, the winner's read_data is loaded from memory_out_data and held until that requester's next read acknowledge.
  - For a write, read_data is unchanged.
  - Go to IDLE.
- Latency: request seen in IDLE at edge N gives the acknowledge high in cycle N+2. Throughput is one access per 3 cycles, with back-to-back requests allowed.
- Capture is at the grant; later changes to address or data on the requester side do not affect the access in flight.
- A request dropped before its acknowledge is a protocol violation. The access still completes and the acknowledge is still pulsed.
- Arbitration (default, macro absent): fixed priority, loader over core. If both requests are high in IDLE, the loader wins.
- core_stall = loader_request OR (state != IDLE AND captured id = loader). It is combinational from registered state and the input, so the core sees the stall in the same cycle.
- Never assert memory_read and memory_write together. Never acknowledge both requesters in the same cycle.
- Reset during ACCESS or RESPOND:
  - Return to IDLE with no acknowledge.
  - A write in ACCESS at the reset edge is already presented to the RAM and completes.
  - The requester must re-issue.

Optional Feature:
- Macro: ARBITER_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. A one-bit pointer names the last granted requester and is updated on every grant. On simultaneous requests the other requester wins. A single requester always wins regardless of the pointer.
- Undefined: fixed loader-over-core priority; the pointer logic is not built.
- core_stall definition is identical in both builds.

Test Plan:
- Core read alone: preload RAM[0x3000] = 0xBEEF; core_request = 1, core_write = 0, core_address = 0x3000 → memory_read = 1 in the cycle after the request edge; core_acknowledge pulses 2 cycles after the request; core_read_data = 0xBEEF.
- Loader write then core read: loader writes 0x1234 to 0x0010, then core reads 0x0010 → loader_acknowledge, then core_acknowledge three or more cycles later; core_read_data = 0x1234; core_stall = 1 throughout the loader access.
- Simultaneous requests, macro undefined: both requests high for 4 accesses each → all 4 loader acknowledges occur before any core acknowledge; strobes are never both 1.
- Simultaneous requests, ARBITER_ROUND_ROBIN_EN defined, pointer = core after reset → grant order loader, core, loader, core…; each acknowledge is spaced 3 cycles apart.
- Reset mid-operation: core read issued, reset asserted in RESPOND → no core_acknowledge; state IDLE, all outputs 0 next cycle; a re-issued read returns correct data.
- Protocol violation: loader_request dropped in ACCESS → loader_acknowledge still pulses once; the arbiter returns to IDLE and serves a pending core request next.
